// File: rtl/nibbler_control_unit.sv
// Nibbler 4-bit CPU control unit: fetches two ROM bytes per instruction, then
// executes in one cycle, driving active-low datapath strobes and the C/Z flags.
module nibbler_control_unit #(
    parameter int unsigned PC_W   = 12,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [7:0]        rom_data,
    input  logic [DATA_W:0]   alu_result,
    output logic [PC_W-1:0]   rom_addr,
    output logic [3:0]        ir_op,
    output logic [3:0]        operand,
    output logic [PC_W-1:0]   ram_addr,
    output logic [1:0]        alu_op,
    output logic              alu_src,
    output logic              notLoadA,
    output logic              notRamWE,
    output logic              notOutWE,
    output logic              notInOE,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              busy
);

    typedef enum logic [1:0] {
        FETCH0 = 2'd0,
        FETCH1 = 2'd1,
        EXEC   = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0, OP_JNC  = 4'h1, OP_JZ   = 4'h2, OP_JNZ  = 4'h3,
        OP_LDI  = 4'h4, OP_LDM  = 4'h5, OP_ADDI = 4'h6, OP_ADDM = 4'h7,
        OP_NORI = 4'h8, OP_NORM = 4'h9, OP_STM  = 4'hA, OP_CMPI = 4'hB,
        OP_CMPM = 4'hC, OP_OUT  = 4'hD, OP_IN   = 4'hE, OP_JMP  = 4'hF
    } opcode_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            c_q, z_q;
    opcode_t         op;
    logic            jump_taken;
    logic            upd_c, upd_z;

    assign op       = opcode_t'(ir[15:12]);
    assign rom_addr = pc;
    assign ir_op    = ir[15:12];
    assign operand  = ir[3:0];
    assign ram_addr = PC_W'(ir[11:0]);
    assign carry_flag = c_q;
    assign zero_flag  = z_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; run only matters at an instruction boundary
    always_comb begin
        state_next = state;
        case (state)
            FETCH0:  if (run) state_next = FETCH1;
            FETCH1:  state_next = EXEC;
            EXEC:    state_next = FETCH0;
            default: state_next = FETCH0;
        endcase
    end

    // Decode: strobes depend only on registered state and IR
    always_comb begin
        notLoadA   = 1'b1;
        notRamWE   = 1'b1;
        notOutWE   = 1'b1;
        notInOE    = 1'b1;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        jump_taken = 1'b0;
        upd_c      = 1'b0;
        upd_z      = 1'b0;
        busy       = (state == FETCH1) || (state == EXEC);
        if (state == EXEC) begin
            case (op)
                OP_JC:   jump_taken = c_q;
                OP_JNC:  jump_taken = ~c_q;
                OP_JZ:   jump_taken = z_q;
                OP_JNZ:  jump_taken = ~z_q;
                OP_JMP:  jump_taken = 1'b1;
                OP_LDI:  begin notLoadA = 1'b0; upd_z = 1'b1; end
                OP_LDM:  begin notLoadA = 1'b0; alu_src = 1'b1; upd_z = 1'b1; end
                OP_ADDI: begin alu_op = 2'b01; notLoadA = 1'b0; upd_c = 1'b1; upd_z = 1'b1; end
                OP_ADDM: begin alu_op = 2'b01; alu_src = 1'b1; notLoadA = 1'b0; upd_c = 1'b1; upd_z = 1'b1; end
                OP_NORI: begin alu_op = 2'b10; notLoadA = 1'b0; upd_z = 1'b1; end
                OP_NORM: begin alu_op = 2'b10; alu_src = 1'b1; notLoadA = 1'b0; upd_z = 1'b1; end
                OP_STM:  notRamWE = 1'b0;
                OP_CMPI: begin alu_op = 2'b11; upd_c = 1'b1; upd_z = 1'b1; end
                OP_CMPM: begin alu_op = 2'b11; alu_src = 1'b1; upd_c = 1'b1; upd_z = 1'b1; end
                OP_OUT:  notOutWE = 1'b0;
                OP_IN:   begin notInOE = 1'b0; alu_src = 1'b1; notLoadA = 1'b0; upd_z = 1'b1; end
                default: ;
            endcase
        end
    end

    // PC, IR and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= '0;
            ir  <= '0;
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            case (state)
                FETCH0: begin
                    if (run) begin
                        ir[15:8] <= rom_data;
                        pc       <= pc + PC_W'(1);
                    end
                end
                FETCH1: begin
                    ir[7:0] <= rom_data;
                    pc      <= pc + PC_W'(1);
                end
                EXEC: begin
                    if (jump_taken) pc <= ram_addr;
                    if (upd_c) c_q <= alu_result[DATA_W];
                    if (upd_z) z_q <= (alu_result[DATA_W-1:0] == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibbler_control_unit.sv
// Self-checking bench for nibbler_control_unit: ISA-level model predicts each
// instruction's decode, strobes, next PC and flags into a scoreboard queue.
module tb_nibbler_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  rom_data;
    logic [4:0]  alu_result;
    logic [11:0] rom_addr;
    logic [3:0]  ir_op;
    logic [3:0]  operand;
    logic [11:0] ram_addr;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        notLoadA, notRamWE, notOutWE, notInOE;
    logic        carry_flag, zero_flag, busy;

    logic [7:0]  rom [4096];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    nibbler_control_unit #(.PC_W(12), .DATA_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .rom_data   (rom_data),
        .alu_result (alu_result),
        .rom_addr   (rom_addr),
        .ir_op      (ir_op),
        .operand    (operand),
        .ram_addr   (ram_addr),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .notLoadA   (notLoadA),
        .notRamWE   (notRamWE),
        .notOutWE   (notOutWE),
        .notInOE    (notInOE),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .busy       (busy)
    );

    typedef struct {
        logic [11:0] pc;
        logic        c, z;
        logic [3:0]  strobes;   // {notLoadA, notRamWE, notOutWE, notInOE}
        logic [1:0]  op;
        logic        src;
        logic [3:0]  irop;
        logic [3:0]  opnd;
        logic [11:0] ra;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [11:0] mpc;
    logic        mc, mz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1, input logic [4:0] alu);
        exp_t e;
        logic take, uc, uz;
        e.pc = mpc + 12'd2;
        e.c = mc;
        e.z = mz;
        e.strobes = 4'hF;
        e.op = 2'b00;
        e.src = 1'b0;
        e.irop = b0[7:4];
        e.opnd = b1[3:0];
        e.ra = {b0[3:0], b1};
        take = 1'b0; uc = 1'b0; uz = 1'b0;
        case (b0[7:4])
            4'h0: take = mc;
            4'h1: take = ~mc;
            4'h2: take = mz;
            4'h3: take = ~mz;
            4'hF: take = 1'b1;
            4'h4: begin e.strobes = 4'h7; uz = 1'b1; end
            4'h5: begin e.strobes = 4'h7; e.src = 1'b1; uz = 1'b1; end
            4'h6: begin e.strobes = 4'h7; e.op = 2'b01; uc = 1'b1; uz = 1'b1; end
            4'h7: begin e.strobes = 4'h7; e.op = 2'b01; e.src = 1'b1; uc = 1'b1; uz = 1'b1; end
            4'h8: begin e.strobes = 4'h7; e.op = 2'b10; uz = 1'b1; end
            4'h9: begin e.strobes = 4'h7; e.op = 2'b10; e.src = 1'b1; uz = 1'b1; end
            4'hA: e.strobes = 4'hB;
            4'hB: begin e.op = 2'b11; uc = 1'b1; uz = 1'b1; end
            4'hC: begin e.op = 2'b11; e.src = 1'b1; uc = 1'b1; uz = 1'b1; end
            4'hD: e.strobes = 4'hD;
            4'hE: begin e.strobes = 4'h6; e.src = 1'b1; uz = 1'b1; end
            default: ;
        endcase
        if (take) e.pc = e.ra;
        if (uc) e.c = alu[4];
        if (uz) e.z = (alu[3:0] == 4'h0);
        return e;
    endfunction

    // Called at a falling edge with the DUT in FETCH0; returns in the next FETCH0.
    task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [4:0] alu, input bit drop_run);
        exp_t        g;
        logic [11:0] pc1;
        pc1 = mpc + 12'd1;
        rom[mpc] = b0;
        rom[pc1] = b1;
        alu_result = alu;
        run = 1'b1;
        sb.push_back(model(b0, b1, alu));
        check_eq("f0_addr", rom_addr, mpc);
        check_eq("f0_busy", busy, 1'b0);
        @(negedge clk);
        check_eq("f1_addr", rom_addr, pc1);
        check_eq("f1_busy", busy, 1'b1);
        check_eq("f1_strobes", {notLoadA, notRamWE, notOutWE, notInOE}, 4'hF);
        if (drop_run) run = 1'b0;
        @(negedge clk);
        g = sb.pop_front();
        check_eq("ex_busy", busy, 1'b1);
        check_eq("ex_irop", ir_op, g.irop);
        check_eq("ex_operand", operand, g.opnd);
        check_eq("ex_ramaddr", ram_addr, g.ra);
        check_eq("ex_strobes", {notLoadA, notRamWE, notOutWE, notInOE}, g.strobes);
        check_eq("ex_aluop", alu_op, g.op);
        check_eq("ex_alusrc", alu_src, g.src);
        @(negedge clk);
        check_eq("pc_next", rom_addr, g.pc);
        check_eq("carry", carry_flag, g.c);
        check_eq("zero", zero_flag, g.z);
        check_eq("f0_strobes", {notLoadA, notRamWE, notOutWE, notInOE, alu_op, alu_src}, 7'h78);
        mpc = g.pc;
        mc  = g.c;
        mz  = g.z;
        if (drop_run) begin
            repeat (3) begin
                @(negedge clk);
                check_eq("idle_pc", rom_addr, mpc);
                check_eq("idle_busy", busy, 1'b0);
            end
            run = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        reset = 1'b1;
        run = 1'b0;
        alu_result = 5'h00;
        mpc = 12'h000; mc = 1'b0; mz = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_pc", rom_addr, 12'h000);
        check_eq("rst_ir", {ir_op, operand, ram_addr}, 20'h0);
        check_eq("rst_flags", {carry_flag, zero_flag}, 2'b00);
        check_eq("rst_outs", {notLoadA, notRamWE, notOutWE, notInOE, alu_op, alu_src, busy}, 8'hF0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_norun_pc", rom_addr, 12'h000);
        check_eq("idle_norun_busy", busy, 1'b0);

        // ADDI with carry-out and zero result
        run_instr(8'h67, 8'h00, 5'h10, 1'b0);

        // Asynchronous reset in the middle of EXEC of an ADDI
        rom[mpc] = 8'h67;
        rom[mpc + 12'd1] = 8'h05;
        alu_result = 5'h13;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_nla", notLoadA, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("arst_pc", rom_addr, 12'h000);
        check_eq("arst_nla", notLoadA, 1'b1);
        check_eq("arst_flags", {carry_flag, zero_flag}, 2'b00);
        @(posedge clk);
        #1;
        check_eq("arst_edge", {rom_addr, busy, notLoadA, carry_flag, zero_flag}, {12'h000, 4'b0100});
        @(negedge clk);
        reset = 1'b0;
        mpc = 12'h000; mc = 1'b0; mz = 1'b0;

        // JZ taken and not taken
        run_instr(8'h40, 8'h00, 5'h00, 1'b0);
        run_instr(8'h21, 8'h23, 5'h00, 1'b0);
        run_instr(8'h40, 8'h05, 5'h05, 1'b0);
        run_instr(8'h21, 8'h23, 5'h00, 1'b0);

        // Jump to the top of ROM, then an instruction straddling the wrap
        run_instr(8'hFF, 8'hFF, 5'h00, 1'b0);
        run_instr(8'hF0, 8'h40, 5'h00, 1'b0);

        // run dropped during FETCH1
        run_instr(8'h4A, 8'h00, 5'h0A, 1'b1);

        // CMPI then STM
        run_instr(8'hB3, 8'h00, 5'h10, 1'b0);
        run_instr(8'hA2, 8'hAB, 5'h07, 1'b0);

        // Random mix across every opcode
        for (int k = 0; k < 48; k++) begin
            logic [7:0] b0;
            logic [7:0] b1;
            logic [4:0] alu;
            b0  = {4'(k % 16), 4'($urandom_range(0, 15))};
            b1  = 8'($urandom_range(0, 255));
            alu = 5'($urandom_range(0, 31));
            run_instr(b0, b1, alu, (k % 11) == 5);
        end

        check_eq("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
